spm_responder: RTL and testbench

//  Responder end of the SPM interface driven by the MEM stage bus_if: a scratchpad memory.
//  - Accepts single-cycle word reads/writes from the core.
//  - Offers a secondary loader port (program/data fill, debug peek) at lower priority.
//  - After reset, zero-clears the array before first use and flags busy so hart control can stall.

---
 rtl/spm_responder_pkg.sv | 8 +
 rtl/spm_responder_array.sv | 19 +
 rtl/spm_responder.sv | 71 +++++++
 tb/tb_spm_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spm_responder_pkg.sv
// spm_responder_pkg: bus widths, core access encodings and FSM states for the scratchpad
package spm_responder_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic {ST_CLEAR, ST_RUN} spm_state_t;
endpackage

// File: rtl/spm_responder_array.sv
// spm_responder_array: word storage with one synchronous write port and two asynchronous read ports
module spm_responder_array import spm_responder_pkg::*; #(
  parameter int SPM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [SPM_ADDR_W-1:0]  waddr,
  input  logic [WORD_DATA_W-1:0] wdata,
  input  logic [SPM_ADDR_W-1:0]  core_addr,
  output logic [WORD_DATA_W-1:0] core_data,
  input  logic [SPM_ADDR_W-1:0]  ld_addr,
  output logic [WORD_DATA_W-1:0] ld_data
);
  logic [WORD_DATA_W-1:0] mem [2**SPM_ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign core_data = mem[core_addr];
  assign ld_data   = mem[ld_addr];
endmodule

// File: rtl/spm_responder.sv
// spm_responder: scratchpad memory with post-reset zero clear, core port and low-priority loader port
module spm_responder import spm_responder_pkg::*; #(
  parameter int SPM_ADDR_W = 12,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_ADDR_W-1:0] spm_addr,
  input  logic                   spm_as_,
  input  logic                   spm_rw,
  input  logic [WORD_DATA_W-1:0] spm_wr_data,
  output logic [WORD_DATA_W-1:0] spm_rd_data,
  output logic                   spm_busy,
  output logic                   spm_oob,
  input  logic                   ld_req,
  input  logic                   ld_we,
  input  logic [SPM_ADDR_W-1:0]  ld_addr,
  input  logic [WORD_DATA_W-1:0] ld_wr_data,
  output logic                   ld_gnt,
  output logic                   ld_rd_valid,
  output logic [WORD_DATA_W-1:0] ld_rd_data
);
  spm_state_t             state;
  logic [SPM_ADDR_W-1:0]  clr_ptr;
  logic                   run, core_acc, hi_set, core_wr, ld_wr, we;
  logic [SPM_ADDR_W-1:0]  waddr;
  logic [WORD_DATA_W-1:0] wdata, core_data, ld_data;

  assign run      = state == ST_RUN;
  assign core_acc = run && !spm_as_;
  // Shifting instead of slicing keeps the decode legal when the array spans the full address
  assign hi_set   = |(spm_addr >> SPM_ADDR_W);
  assign spm_oob  = core_acc && hi_set;
  assign spm_busy = !run;
  assign core_wr  = core_acc && !hi_set && spm_rw == WRITE;
  assign ld_gnt   = run && ld_req && spm_as_;
  assign ld_wr    = ld_gnt && ld_we;

  assign spm_rd_data = (core_acc && !hi_set && spm_rw == READ) ? core_data : '0;

  assign we    = reset && (!run || core_wr || ld_wr);
  assign waddr = !run ? clr_ptr : core_wr ? spm_addr[SPM_ADDR_W-1:0] : ld_addr;
  assign wdata = !run ? '0 : core_wr ? spm_wr_data : ld_wr_data;

  spm_responder_array #(.SPM_ADDR_W(SPM_ADDR_W)) u_array (
    .clk       (clk),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .core_addr (spm_addr[SPM_ADDR_W-1:0]),
    .core_data (core_data),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= CLEAR_EN ? ST_CLEAR : ST_RUN;
      clr_ptr     <= '0;
      ld_rd_valid <= 1'b0;
      ld_rd_data  <= '0;
    end else begin
      if (!run) begin
        clr_ptr <= clr_ptr + SPM_ADDR_W'(1);
        if (&clr_ptr) state <= ST_RUN;
      end
      ld_rd_valid <= ld_gnt && !ld_we;
      if (ld_gnt && !ld_we) ld_rd_data <= ld_data;
    end
  end
endmodule

// File: tb/tb_spm_responder.sv
// tb_spm_responder: randomized and directed checks of spm_responder against an array model
module tb_spm_responder;
  import spm_responder_pkg::*;
  localparam int AW = 4;
  localparam int DEPTH = 2**AW;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] spm_addr = '0;
  logic        spm_as_ = 1'b1;
  logic        spm_rw = READ;
  logic [31:0] spm_wr_data = '0;
  logic [31:0] spm_rd_data;
  logic        spm_busy, spm_oob;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0] ld_wr_data = '0;
  logic        ld_gnt, ld_rd_valid;
  logic [31:0] ld_rd_data;

  int checks = 0, errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_ld_data;

  spm_responder #(.SPM_ADDR_W(AW), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data), .spm_busy(spm_busy), .spm_oob(spm_oob),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wr_data(ld_wr_data),
    .ld_gnt(ld_gnt), .ld_rd_valid(ld_rd_valid), .ld_rd_data(ld_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    spm_as_ = 1'b1; spm_rw = READ; spm_addr = '0; spm_wr_data = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wr_data = '0;
  endtask

  // Holds reset for two edges, releases it, then expects exactly DEPTH busy cycles.
  // With late_wr, a core write is attempted on the last busy cycle to an already-cleared word.
  task automatic do_reset(input bit late_wr);
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (late_wr && i == DEPTH-1) begin
        spm_as_ = 1'b0; spm_rw = WRITE; spm_addr = 30'd2; spm_wr_data = 32'hBAD0_0002;
      end
      #1;
      check("busy_during_clear", 32'(spm_busy), 32'd1);
      if (i == 0 || i == DEPTH-1) begin
        check("rd_during_clear", spm_rd_data, 32'h0);
        check("oob_during_clear", 32'(spm_oob), 32'd0);
      end
      @(posedge clk); #1;
      idle();
    end
    #1 check("busy_after_clear", 32'(spm_busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_ld_data = '0;
    check("ld_rd_data_reset", ld_rd_data, 32'h0);
  endtask

  task automatic cyc(input logic as_n, input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                     input logic lr, input logic lw, input logic [AW-1:0] la, input logic [31:0] lwd);
    logic in_b, gnt;
    logic [31:0] exp_rd;
    spm_as_ = as_n; spm_rw = rw; spm_addr = addr; spm_wr_data = wd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wr_data = lwd;
    in_b = addr < DEPTH;
    gnt = lr && as_n;
    exp_rd = (!as_n && rw == READ && in_b) ? model[addr[AW-1:0]] : 32'h0;
    #1;
    check("core_rd_data", spm_rd_data, exp_rd);
    check("core_oob", 32'(spm_oob), 32'(!as_n && !in_b));
    check("ld_gnt", 32'(ld_gnt), 32'(gnt));
    @(posedge clk);
    if (gnt && !lw) exp_ld_data = model[la];
    if (!as_n && rw == WRITE && in_b) model[addr[AW-1:0]] = wd;
    else if (gnt && lw) model[la] = lwd;
    #1;
    check("ld_rd_valid", 32'(ld_rd_valid), 32'(gnt && !lw));
    check("ld_rd_data", ld_rd_data, exp_ld_data);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      spm_as_ = 1'b0; spm_rw = READ; spm_addr = 30'(i);
      #1 check(tag, spm_rd_data, model[i]);
      check({tag, "_zero"}, spm_rd_data, 32'h0);
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    exp_ld_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(posedge clk); #1;
    do_reset(1'b0);
    read_all("post_reset_word");

    cyc(1'b0, READ,  30'd5, 32'h0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, WRITE, 30'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, READ,  30'd5, 32'h0, 1'b0, 1'b0, '0, '0);
    check("word5_after_write", spm_rd_data, 32'hDEADBEEF);

    cyc(1'b0, WRITE, 30'h10, 32'h1234_5678, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, READ,  30'h0,  32'h0, 1'b0, 1'b0, '0, '0);
    check("word0_after_oob_write", spm_rd_data, 32'h0);
    cyc(1'b0, READ,  30'h10, 32'h0, 1'b0, 1'b0, '0, '0);

    cyc(1'b0, READ,  30'd1, 32'h0, 1'b1, 1'b1, 4'd3, 32'hCAFE_0003);
    cyc(1'b0, WRITE, 30'd7, 32'h7777_7777, 1'b1, 1'b1, 4'd3, 32'hCAFE_0003);
    cyc(1'b1, READ,  30'd0, 32'h0, 1'b1, 1'b1, 4'd3, 32'hCAFE_0003);
    cyc(1'b0, READ,  30'd3, 32'h0, 1'b0, 1'b0, '0, '0);
    check("word3_after_loader", spm_rd_data, 32'hCAFE_0003);

    cyc(1'b1, READ, 30'd0, 32'h0, 1'b1, 1'b0, 4'd5, 32'h0);
    check("ld_read5_data", ld_rd_data, 32'hDEADBEEF);
    cyc(1'b1, READ, 30'd0, 32'h0, 1'b0, 1'b0, '0, '0);
    check("ld_read5_hold", ld_rd_data, 32'hDEADBEEF);

    for (int n = 0; n < 400; n++) begin
      logic [29:0] a;
      a = ($urandom_range(0, 7) == 0) ? 30'($urandom) : 30'($urandom_range(0, DEPTH-1));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom);
    end
    idle();

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("busy_mid_clear", 32'(spm_busy), 32'd1);
    spm_as_ = 1'b0; spm_rw = WRITE; spm_addr = 30'd12; spm_wr_data = 32'hBAD0_000C;
    do_reset(1'b1);
    read_all("mid_clear_word");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
